// File: rtl/ir_encoder.sv
// Pulse-distance IR frame generator: sync burst/silence, one burst+silence per bit
// (MSB first), a final dip, then an idle gap before the block accepts a new trigger.
module ir_encoder #(
   parameter int SBD      = 900,
   parameter int SSD      = 450,
   parameter int BBD      = 60,
   parameter int BSD0     = 60,
   parameter int BSD1     = 160,
   parameter int NUM_BITS = 32,
   parameter int GAP      = 50
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [NUM_BITS-1:0] code_in,
   input  logic                trigger_in,
   output logic                signal_out,
   output logic                busy_out,
   output logic                done_out,
   output logic [2:0]          state_out
);

   localparam int MAX_A   = (SBD > SSD) ? SBD : SSD;
   localparam int MAX_B   = (BBD > BSD0) ? BBD : BSD0;
   localparam int MAX_C   = (BSD1 > GAP) ? BSD1 : GAP;
   localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_DUR = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int CW      = $clog2(MAX_DUR) + 1;
   localparam int BW      = $clog2(NUM_BITS + 1);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_SYNC_BURST   = 3'd1;
   localparam logic [2:0] S_SYNC_SILENCE = 3'd2;
   localparam logic [2:0] S_BIT_BURST    = 3'd3;
   localparam logic [2:0] S_BIT_SILENCE  = 3'd4;
   localparam logic [2:0] S_STOP_BURST   = 3'd5;
   localparam logic [2:0] S_GAP          = 3'd6;

   // Counters hold (duration - 1) on entry; a state ends when its counter reads zero.
   localparam logic [CW-1:0] SBD_L   = CW'(SBD - 1);
   localparam logic [CW-1:0] SSD_L   = CW'(SSD - 1);
   localparam logic [CW-1:0] BBD_L   = CW'(BBD - 1);
   localparam logic [CW-1:0] BSD0_L  = CW'(BSD0 - 1);
   localparam logic [CW-1:0] BSD1_L  = CW'(BSD1 - 1);
   localparam logic [CW-1:0] GAP_L   = CW'(GAP - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [BW-1:0] BIT_ONE = BW'(1);
   localparam logic [BW-1:0] BIT_ZERO = BW'(0);
   localparam logic [BW-1:0] NB_LAST = BW'(NUM_BITS - 1);

   logic [2:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]       bits_q, bits_d;
   logic                signal_q, signal_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                last_s;

   assign last_s = (cnt_q == CNT_ZERO);

   // Next-state, counter and shift-register logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - CNT_ONE;
      shift_d = shift_q;
      bits_d  = bits_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = CNT_ZERO;
            if (trigger_in) begin
               shift_d = code_in;
               bits_d  = BIT_ZERO;
               cnt_d   = SBD_L;
               state_d = S_SYNC_BURST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SYNC_BURST: begin
            if (last_s) begin
               state_d = S_SYNC_SILENCE;
               cnt_d   = SSD_L;
            end else begin
               state_d = S_SYNC_BURST;
            end
         end
         S_SYNC_SILENCE: begin
            if (last_s) begin
               state_d = S_BIT_BURST;
               cnt_d   = BBD_L;
            end else begin
               state_d = S_SYNC_SILENCE;
            end
         end
         S_BIT_BURST: begin
            if (last_s) begin
               state_d = S_BIT_SILENCE;
               cnt_d   = shift_q[NUM_BITS-1] ? BSD1_L : BSD0_L;
            end else begin
               state_d = S_BIT_BURST;
            end
         end
         S_BIT_SILENCE: begin
            if (last_s) begin
               shift_d = shift_q << 1'b1;
               bits_d  = bits_q + BIT_ONE;
               cnt_d   = BBD_L;
               if (bits_q == NB_LAST) begin
                  state_d = S_STOP_BURST;
               end else begin
                  state_d = S_BIT_BURST;
               end
            end else begin
               state_d = S_BIT_SILENCE;
            end
         end
         S_STOP_BURST: begin
            if (last_s) begin
               state_d = S_GAP;
               cnt_d   = GAP_L;
               done_d  = 1'b1;
            end else begin
               state_d = S_STOP_BURST;
            end
         end
         S_GAP: begin
            if (last_s) begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_GAP;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            shift_d = {NUM_BITS{1'b0}};
            bits_d  = BIT_ZERO;
         end
      endcase
   end

   // Output levels follow the state being entered so the registered pins line up with it
   always_comb begin
      case (state_d)
         S_SYNC_BURST, S_BIT_BURST, S_STOP_BURST: signal_d = 1'b0;
         default:                                 signal_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         cnt_q    <= CNT_ZERO;
         shift_q  <= {NUM_BITS{1'b0}};
         bits_q   <= BIT_ZERO;
         signal_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         bits_q   <= bits_d;
         signal_q <= signal_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign signal_out = signal_q;
   assign busy_out   = busy_q;
   assign done_out   = done_q;
   assign state_out  = state_q;

endmodule

// File: tb/tb_ir_encoder.sv
// Self-checking bench for ir_encoder: expected waveform is rebuilt from the
// burst/silence run list of each code word and compared cycle by cycle.
module tb_ir_encoder;
   localparam int SBD = 900, SSD = 450, BBD = 60, BSD0 = 60, BSD1 = 160, GAP = 50;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, trig, sel;
   logic [31:0] code;
   logic        s32, b32, d32, s20, b20, d20;
   logic [2:0]  st32, st20;
   logic        sig_o, busy_o, done_o;
   logic [2:0]  st_o;

   ir_encoder #(.NUM_BITS(32)) u32 (
      .clk_in(clk), .rst_in(rst), .code_in(code), .trigger_in(trig & ~sel),
      .signal_out(s32), .busy_out(b32), .done_out(d32), .state_out(st32));

   ir_encoder #(.NUM_BITS(20)) u20 (
      .clk_in(clk), .rst_in(rst), .code_in(code[19:0]), .trigger_in(trig & sel),
      .signal_out(s20), .busy_out(b20), .done_out(d20), .state_out(st20));

   assign sig_o  = sel ? s20 : s32;
   assign busy_o = sel ? b20 : b32;
   assign done_o = sel ? d20 : d32;
   assign st_o   = sel ? st20 : st32;

   int checks = 0, failures = 0;
   bit exp_sig [0:9999];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected waveform: alternating low/high runs starting low, cycle 1 = first cycle after acceptance
   task automatic build(input logic [31:0] c, input int nb, output int len);
      int runs[$];
      int k;
      bit lv;
      runs = {SBD, SSD};
      for (int i = nb - 1; i >= 0; i--) begin
         runs.push_back(BBD);
         runs.push_back(c[i] ? BSD1 : BSD0);
      end
      runs.push_back(BBD);
      k = 1;
      lv = 1'b0;
      foreach (runs[r]) begin
         for (int j = 0; j < runs[r]; j++) begin
            exp_sig[k] = lv;
            k++;
         end
         lv = ~lv;
      end
      len = k - 1;
   endtask

   task automatic run_frame(input logic [31:0] c, input bit nb20, input bit already,
                            input bit hold, input logic [31:0] next_c,
                            input int inject_k, input int reset_k);
      int len, last, nerr, berr, ndone, dcyc;
      bit exp_s, exp_b;
      build(c, nb20 ? 20 : 32, len);
      sel = nb20;
      if (!already) begin
         code = c;
         trig = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!hold) trig = 1'b0;
      nerr = 0; berr = 0; ndone = 0; dcyc = -1;
      last = (reset_k > 0) ? reset_k + 1 : len + GAP + 1;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (reset_k > 0 && k == reset_k + 1) begin
            check_eq("rst_sig", sig_o, 1'b1);
            check_eq("rst_busy", busy_o, 1'b0);
            check_eq("rst_state", st_o, 3'd0);
            check_eq("rst_done", done_o, 1'b0);
            rst = 1'b0;
         end else begin
            exp_s = (k <= len) ? exp_sig[k] : 1'b1;
            exp_b = (k <= len + GAP);
            if (sig_o !== exp_s) nerr++;
            if (busy_o !== exp_b) berr++;
            if (done_o === 1'b1) begin
               ndone++;
               dcyc = k;
            end
            if (k == 1) check_eq("state_first", st_o, 3'd1);
            if (reset_k == 0 && k == last) check_eq("state_end", st_o, 3'd0);
            if (inject_k > 0 && k == inject_k) begin
               code = ~c;
               trig = 1'b1;
            end
            if (inject_k > 0 && k == inject_k + 1) begin
               code = c;
               trig = hold;
            end
            if (hold && k == 500) code = next_c;
            if (reset_k > 0 && k == reset_k) rst = 1'b1;
         end
      end
      check_eq("wave_errs", nerr, 0);
      check_eq("busy_errs", berr, 0);
      if (reset_k > 0) begin
         check_eq("done_cnt_rst", ndone, 0);
      end else begin
         check_eq("done_cnt", ndone, 1);
         check_eq("done_cycle", dcyc, len + 1);
      end
   endtask

   initial begin
      rst = 1'b1; trig = 1'b0; sel = 1'b0; code = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_sig32", s32, 1'b1);
      check_eq("reset_busy32", b32, 1'b0);
      check_eq("reset_done32", d32, 1'b0);
      check_eq("reset_state32", st32, 3'd0);
      check_eq("reset_sig20", s20, 1'b1);
      check_eq("reset_state20", st20, 3'd0);
      rst = 1'b0;
      @(negedge clk);

      run_frame(32'hABCD1234, 1'b0, 1'b0, 1'b0, 32'h0, 100, 0);
      run_frame(32'h00000000, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
      run_frame(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
      run_frame(32'hABCD1234, 1'b0, 1'b0, 1'b0, 32'h0, 0, 3000);
      run_frame($urandom, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
      run_frame(32'h19861989, 1'b0, 1'b0, 1'b1, 32'hABCD1234, 0, 0);
      run_frame(32'hABCD1234, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
      run_frame($urandom, 1'b0, 1'b0, 1'b0, 32'h0, 200, 0);
      run_frame(32'h000ABCD1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
      run_frame({12'h0, 20'($urandom)}, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
